// File: rtl/ntt_pair_reader_if.sv
// Beat stream from the pair reader toward the butterfly datapath.
// Ports: m_valid/m_data/m_last driven by master, m_ready by slave.
interface ntt_pair_reader_if #(
    parameter int WIDTH = 8
);
    logic                 m_valid;
    logic                 m_ready;
    logic [2*WIDTH-1:0]   m_data;
    logic                 m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/ntt_pair_reader.sv
// Reads even/odd coefficient pairs from a dual-port RAM and streams them.
// Ports: clk/rst, start/base/npairs/busy/done, RAM ports A/B, stream m.
module ntt_pair_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    base,
    input  logic [AW-1:0]    npairs,
    output logic             busy,
    output logic             done,
    output logic             ena,
    output logic             wea,
    output logic [AW-1:0]    addra,
    input  logic [WIDTH-1:0] doa,
    output logic             enb,
    output logic             web,
    output logic [AW-1:0]    addrb,
    input  logic [WIDTH-1:0] dob,
    ntt_pair_reader_if.master m
);
    localparam logic [AW-1:0] ONE = AW'(1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state, state_nx;
    logic [AW-1:0]      base_q, np_q;
    logic [AW-1:0]      issued, accepted;
    logic [AW-1:0]      rd_addr;
    logic               inflight;
    logic [2*WIDTH-1:0] mem [2];
    logic               wptr, rptr;
    logic [1:0]         count;
    logic               pop, issue;
    logic [2:0]         occ, room;

    assign pop       = m.m_valid & m.m_ready;
    assign m.m_valid = (count != 2'd0);
    assign m.m_data  = mem[rptr];
    assign m.m_last  = m.m_valid & (accepted == np_q - ONE);

    // Data issued now lands in the FIFO two edges later; allow an issue
    // only if the FIFO plus the pending capture still leaves a free slot.
    assign occ  = {1'b0, count} + {2'b0, inflight};
    assign room = 3'd1 + {2'b0, pop};

    assign rd_addr = base_q + (issued << 1);
    assign wea     = 1'b0;
    assign web     = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = (npairs == '0) ? FIN : RUN;
            RUN:  if (pop && m.m_last) state_nx = FIN;
            FIN:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        issue = 1'b0;
        unique case (state)
            IDLE: busy = start;
            RUN: begin
                busy  = 1'b1;
                issue = (issued < np_q) && (occ <= room);
            end
            FIN: done = 1'b1;
            default: ;
        endcase
        ena   = issue;
        enb   = issue;
        addra = issue ? rd_addr : '0;
        addrb = issue ? (rd_addr | ONE) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q   <= '0;
            np_q     <= '0;
            issued   <= '0;
            accepted <= '0;
            inflight <= 1'b0;
            mem[0]   <= '0;
            mem[1]   <= '0;
            wptr     <= 1'b0;
            rptr     <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (state == IDLE && start) begin
                base_q   <= base & ~ONE;
                np_q     <= npairs;
                issued   <= '0;
                accepted <= '0;
            end
            if (issue) issued <= issued + ONE;
            if (pop) begin
                accepted <= accepted + ONE;
                rptr     <= ~rptr;
            end
            inflight <= issue;
            if (inflight) begin
                mem[wptr] <= {dob, doa};
                wptr      <= ~wptr;
            end
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_ntt_pair_reader.sv
// Self-checking bench for ntt_pair_reader with a behavioural RAM model.
// Expected beats/addresses derive from base, npairs and RAM contents.
module tb_ntt_pair_reader;
    localparam int W  = 8;
    localparam int D  = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base, npairs;
    logic          busy, done, ena, wea, enb, web;
    logic [AW-1:0] addra, addrb;
    logic [W-1:0]  doa, dob;
    logic [W-1:0]  ram [D];

    int checks = 0;
    int errors = 0;

    ntt_pair_reader_if #(.WIDTH(W)) sif ();

    ntt_pair_reader #(.WIDTH(W), .DEPTH(D), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base),
        .npairs(npairs), .busy(busy), .done(done),
        .ena(ena), .wea(wea), .addra(addra), .doa(doa),
        .enb(enb), .web(web), .addrb(addrb), .dob(dob),
        .m(sif.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ena) doa <= ram[addra];
        if (enb) dob <= ram[addrb];
    end

    task automatic fill_ramp();
        for (int i = 0; i < D; i++) ram[i] = W'(i);
    endtask

    task automatic fill_random();
        for (int i = 0; i < D; i++) ram[i] = W'($urandom);
    endtask

    // rmode: 0 always ready, 1 pattern 1,0,0,1,0,1, 2 random
    task automatic do_pass(input int b, input int n,
                           input int rmode, input bit restart);
        int        issues = 0, beats = 0, cyc = 0;
        int        first_v = -1, last_acc = -1;
        int        budget = 40 + 16 * n;
        int        a;
        bit        seen_done = 0;
        bit        pv = 0, pr = 0, pl = 0;
        logic [15:0] pd = '0, ed;
        bit        pat [6] = '{1, 0, 0, 1, 0, 1};
        @(posedge clk); #1;
        start = 1'b1; base = AW'(b); npairs = AW'(n);
        sif.m_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_at_start got=%b want=1", busy);
        end
        while (!seen_done && cyc < budget) begin
            @(posedge clk); #1;
            start = restart && (cyc == 1);
            npairs = restart ? AW'(7) : AW'(n);
            case (rmode)
                0: sif.m_ready = 1'b1;
                1: sif.m_ready = pat[cyc % 6];
                default: sif.m_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            checks++;
            if (wea !== 1'b0 || web !== 1'b0 || ena !== enb) begin
                errors++;
                $display("FAIL port_ctl wea=%b web=%b ena=%b enb=%b",
                         wea, web, ena, enb);
            end
            if (ena) begin
                a = ((b & ~1) + 2 * issues) % D;
                checks++;
                if (issues >= n || addra !== AW'(a)
                    || addrb !== AW'(a + 1)) begin
                    errors++;
                    $display("FAIL issue_addr k=%0d got=(%0d,%0d) want=(%0d,%0d)",
                             issues, addra, addrb, a, a + 1);
                end
                issues++;
            end
            if (pv && !pr) begin
                checks++;
                if (sif.m_valid !== 1'b1 || sif.m_data !== pd
                    || sif.m_last !== pl) begin
                    errors++;
                    $display("FAIL stall_hold got=%b/%h/%b want=1/%h/%b",
                             sif.m_valid, sif.m_data, sif.m_last, pd, pl);
                end
            end
            if (sif.m_valid && first_v < 0) begin
                first_v = cyc;
                checks++;
                if (cyc != 2) begin
                    errors++;
                    $display("FAIL first_valid got=%0d want=2", cyc);
                end
            end
            if (sif.m_valid) begin
                a = ((b & ~1) + 2 * beats) % D;
                ed = {ram[(a + 1) % D], ram[a]};
                checks++;
                if (beats >= n || sif.m_data !== ed
                    || sif.m_last !== (beats == n - 1)) begin
                    errors++;
                    $display("FAIL beat k=%0d got=%h/%b want=%h/%b",
                             beats, sif.m_data, sif.m_last, ed,
                             beats == n - 1);
                end
                if (sif.m_ready) begin
                    beats++;
                    if (beats == n) last_acc = cyc;
                end
            end
            if (done) begin
                seen_done = 1;
                checks++;
                if (beats != n || busy !== 1'b0
                    || (n > 0 && cyc != last_acc + 1)) begin
                    errors++;
                    $display("FAIL done beats=%0d/%0d busy=%b cyc=%0d last=%0d",
                             beats, n, busy, cyc, last_acc);
                end
            end else begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_run got=%b want=1", busy);
                end
            end
            pv = sif.m_valid; pr = sif.m_ready;
            pd = sif.m_data;  pl = sif.m_last;
            cyc++;
        end
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL timeout b=%0d n=%0d beats=%0d", b, n, beats);
        end
        @(posedge clk); #1;
        start = 1'b0;
        sif.m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base = '0; npairs = '0;
        sif.m_ready = 1'b0;
        #12;
        checks++;
        if ({busy, done, ena, enb, sif.m_valid, sif.m_last} !== 6'b0
            || addra !== '0 || addrb !== '0 || sif.m_data !== '0) begin
            errors++;
            $display("FAIL reset_state ctl=%b a=%0d b=%0d d=%h",
                     {busy, done, ena, enb, sif.m_valid, sif.m_last},
                     addra, addrb, sif.m_data);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        fill_ramp();
        do_pass(0, 4, 0, 0);
    endtask

    task automatic test_backpressure();
        fill_ramp();
        do_pass(0, 4, 1, 0);
        do_pass(8, 9, 1, 0);
    endtask

    task automatic test_wrap();
        fill_ramp();
        do_pass(62, 2, 0, 0);
    endtask

    task automatic test_odd_zero();
        fill_ramp();
        do_pass(5, 1, 0, 0);
        do_pass(12, 0, 0, 0);
    endtask

    task automatic test_start_busy();
        fill_ramp();
        do_pass(20, 3, 0, 1);
    endtask

    task automatic test_async_reset();
        int  k = 0;
        bit  got_done = 0, got_valid = 0;
        fill_ramp();
        @(posedge clk); #1;
        start = 1'b1; base = AW'(10); npairs = AW'(4);
        sif.m_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        while (!sif.m_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!sif.m_valid) begin
            errors++;
            $display("FAIL rst_setup got=%b want=1", sif.m_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, ena, enb, sif.m_valid, sif.m_last} !== 6'b0
            || addra !== '0 || sif.m_data !== '0) begin
            errors++;
            $display("FAIL rst_midpass ctl=%b a=%0d d=%h",
                     {busy, done, ena, enb, sif.m_valid, sif.m_last},
                     addra, sif.m_data);
        end
        @(negedge clk);
        rst = 1'b0;
        sif.m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) got_done = 1;
            if (sif.m_valid) got_valid = 1;
        end
        checks++;
        if (got_done || got_valid) begin
            errors++;
            $display("FAIL rst_quiet done=%b valid=%b want=0/0",
                     got_done, got_valid);
        end
        sif.m_ready = 1'b0;
        do_pass(30, 3, 0, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 12; t++) begin
            fill_random();
            do_pass($urandom_range(0, D - 1), $urandom_range(0, D / 2),
                    2, 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_odd_zero();
        test_start_busy();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
